// File: rtl/fp_pkg.sv
// Shared fixed-point types, width helpers and range-limit helpers for the
// accumulator and later MAC blocks.
package fp_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int unsigned MAX_W = 64;

    function automatic int unsigned data_width(input int unsigned int_bits,
                                               input int unsigned frac_bits);
        return int_bits + frac_bits;
    endfunction

    // One guard bit beyond clog2(len) keeps both signed and unsigned sums exact.
    function automatic int unsigned acc_width(input int unsigned w,
                                              input int unsigned len);
        return w + $clog2(len) + 1;
    endfunction

    function automatic logic [MAX_W-1:0] range_max(input bit is_signed,
                                                   input int unsigned w);
        if (is_signed)
            return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
        else if (w >= MAX_W)
            return '1;
        else
            return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] range_min(input bit is_signed,
                                                   input int unsigned w);
        if (is_signed)
            return ~((MAX_W'(1) << (w - 1)) - MAX_W'(1));
        else
            return '0;
    endfunction

endpackage

// File: rtl/fp_sat.sv
// Range check of a wide sum against the W-bit format; clamps when
// FP_ACC_SATURATE_EN is defined, otherwise keeps the low W bits.
module fp_sat
    import fp_pkg::*;
#(
    parameter int SIGNED = 1,
    parameter int W      = 16,
    parameter int AW     = 21
) (
    input  logic [AW-1:0] sum,
    output logic [W-1:0]  data,
    output logic          ovf
);

`ifdef FP_ACC_SATURATE_EN
    localparam logic [MAX_W-1:0] HI_FULL = range_max(SIGNED != 0, W);
    localparam logic [MAX_W-1:0] LO_FULL = range_min(SIGNED != 0, W);
    localparam logic [W-1:0]     HI      = HI_FULL[W-1:0];
    localparam logic [W-1:0]     LO      = LO_FULL[W-1:0];
`endif

    always_comb begin
        data = sum[W-1:0];
        ovf  = 1'b0;
        // In range exactly when all bits above the kept field match its top bit.
        if (SIGNED != 0)
            ovf = !((&sum[AW-1:W-1]) || !(|sum[AW-1:W-1]));
        else
            ovf = |sum[AW-1:W];
`ifdef FP_ACC_SATURATE_EN
        if (ovf)
            data = ((SIGNED != 0) && sum[AW-1]) ? LO : HI;
`endif
    end

endmodule

// File: rtl/fp_accumulator.sv
// Sums ACC_LEN fixed-point operands per result with valid/ready handshakes.
// Define FP_ACC_SATURATE_EN to clamp out-of-range results instead of wrapping.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int SIGNED   = 1,
    parameter int INTEGER  = 2,
    parameter int FRACTION = 14,
    parameter int ACC_LEN  = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INTEGER+FRACTION-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INTEGER+FRACTION-1:0]   out_data,
    output logic                          out_ovf
);

    localparam int W   = int'(data_width(INTEGER, FRACTION));
    localparam int AW  = int'(acc_width(W, ACC_LEN));
    localparam int CW  = $clog2(ACC_LEN);
    localparam int EXT = AW - W;
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

    acc_state_t    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [AW-1:0] operand;
    logic [AW-1:0] sum;
    logic [W-1:0]  sat_data;
    logic          sat_ovf;

    always_comb begin
        operand = (SIGNED != 0) ? {{EXT{in_data[W-1]}}, in_data}
                                : {{EXT{1'b0}}, in_data};
        sum     = acc + operand;
    end

    fp_sat #(
        .SIGNED (SIGNED),
        .W      (W),
        .AW     (AW)
    ) u_sat (
        .sum  (sum),
        .data (sat_data),
        .ovf  (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        if (cnt == LAST) begin
                            out_data  <= sat_data;
                            out_ovf   <= sat_ovf;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator (Q2.14, ACC_LEN=9); expectations follow
// FP_ACC_SATURATE_EN when it is defined for the build.
module tb_fp_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    logic [15:0] ops [9];

    typedef struct {
        string       name;
        logic [15:0] operand;
        int          max_gap;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [5];

    fp_accumulator #(
        .SIGNED   (1),
        .INTEGER  (2),
        .FRACTION (14),
        .ACC_LEN  (9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum of nine Q2.14 values, then range rule.
    function automatic void model(output logic [15:0] d, output logic o);
        longint s;
        s = 0;
        for (int i = 0; i < 9; i++)
            s += longint'($signed(ops[i]));
        o = (s > 32767) || (s < -32768);
        d = s[15:0];
`ifdef FP_ACC_SATURATE_EN
        if (s > 32767)
            d = 16'h7FFF;
        else if (s < -32768)
            d = 16'h8000;
`endif
    endfunction

    task automatic run_burst(input string name, input int max_gap, input int hold,
                             input logic [15:0] exp_d, input logic exp_o);
        for (int i = 0; i < 9; i++) begin
            int g;
            int t;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            in_valid = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            t = 0;
            while (!in_ready && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            check({name, "_in_ready_accum"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = ops[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        check({name, "_latency_out_valid"}, 32'(out_valid), 32'd1);
        check({name, "_out_data"}, 32'(out_data), 32'(exp_d));
        check({name, "_out_ovf"}, 32'(out_ovf), 32'(exp_o));
        check({name, "_in_ready_hold"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 16'h4000;
            @(posedge clk);
            #1;
            check({name, "_stall_out_valid"}, 32'(out_valid), 32'd1);
            check({name, "_stall_out_data"}, 32'(out_data), 32'(exp_d));
            check({name, "_stall_out_ovf"}, 32'(out_ovf), 32'(exp_o));
            check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_consumed_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_consumed_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] md;
        logic        mo;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0] = '{"b2b_0800",  16'h0800, 0, 16'h4800, 1'b0};
`ifdef FP_ACC_SATURATE_EN
        vecs[1] = '{"pos_ovf",   16'h4000, 0, 16'h7FFF, 1'b1};
        vecs[2] = '{"neg_ovf",   16'hC000, 0, 16'h8000, 1'b1};
`else
        vecs[1] = '{"pos_ovf",   16'h4000, 0, 16'h4000, 1'b1};
        vecs[2] = '{"neg_ovf",   16'hC000, 0, 16'hC000, 1'b1};
`endif
        vecs[3] = '{"gaps_0400", 16'h0400, 3, 16'h2400, 1'b0};
        vecs[4] = '{"nogap_0400", 16'h0400, 0, 16'h2400, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            for (int i = 0; i < 9; i++)
                ops[i] = vecs[v].operand;
            run_burst(vecs[v].name, vecs[v].max_gap, 0, vecs[v].exp_data, vecs[v].exp_ovf);
        end

        // Held result must survive a 5-cycle out_ready stall with in_valid pushing.
        for (int i = 0; i < 9; i++)
            ops[i] = 16'h0800;
        run_burst("hold_stall", 0, 5, 16'h4800, 1'b0);
        run_burst("after_stall", 0, 0, 16'h4800, 1'b0);

        // Reset mid-sequence discards the partial sum.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h4000;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        run_burst("post_reset", 0, 0, 16'h4800, 1'b0);

        // Reset while a result is held drops it asynchronously.
        for (int i = 0; i < 9; i++)
            ops[i] = 16'hC000;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("held_before_reset", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("held_reset_out_valid", 32'(out_valid), 32'd0);
        check("held_reset_out_data", 32'(out_data), 32'd0);
        check("held_reset_out_ovf", 32'(out_ovf), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 9; i++)
                ops[i] = 16'($urandom);
            model(md, mo);
            run_burst("random", 2, int'($urandom_range(0, 2)), md, mo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement operands and 0 = unsigned operands.
REQ-002 SHALL have parameter INTEGER, default 2, giving the number of integer bits.
REQ-003 SHALL have parameter FRACTION, default 14, giving the number of fraction bits; W = INTEGER+FRACTION.
REQ-004 SHALL have parameter ACC_LEN, default 9, giving the operands summed per result (e.g. a 3x3 kernel); legal range is 2..1024.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: operand present.
REQ-008 SHALL have port in_ready, output, 1 bit: operand accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_data, input, W bits: fixed-point operand.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port out_data, output, W bits: fixed-point sum.
REQ-013 SHALL have port out_ovf, output, 1 bit: the full-precision sum was outside the W-bit range; qualified by out_valid.

Function
REQ-014 SHALL use an internal accumulator of AW = W + clog2(ACC_LEN) + 1 bits, sign-extending operands when SIGNED=1 and zero-extending them when SIGNED=0; the accumulator never overflows internally.
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 SHALL, in ACCUM, on each accepted beat add in_data to acc and increment cnt (clog2(ACC_LEN) bits); with no beat, acc and cnt hold.
REQ-017 SHALL, on the beat accepted with cnt == ACC_LEN-1, register the final sum and out_ovf, clear acc and cnt, and enter HOLD; out_valid is high the next cycle (latency 1 cycle from the last accepted beat).
REQ-018 SHALL, in HOLD, keep out_data and out_ovf stable until out_valid and out_ready are both high, then return to ACCUM the next cycle.
REQ-019 SHALL NOT accept operands in HOLD; one bubble cycle per result is accepted behaviour.
REQ-020 SHALL compute out_ovf against the W-bit range: signed [-2^(W-1), 2^(W-1)-1]; unsigned [0, 2^W-1].
REQ-021 SHALL treat in_valid low mid-sequence as a stall only; the partial sum is retained indefinitely.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state=ACCUM, acc=0, cnt=0, out_data=0, out_ovf=0, out_valid=0, in_ready=1 (valid from the first cycle after release).
REQ-023 SHALL discard any partial sum or held result when reset asserts mid-operation; no output is produced for it.

Configuration
REQ-024 SHALL, with macro FP_ACC_SATURATE_EN defined, clamp an out-of-range sum to the nearest range limit (signed: 0x7FFF/0x8000 for W=16; unsigned: all ones, or 0 is unreachable).
REQ-025 SHALL, without FP_ACC_SATURATE_EN, output the low W bits of the sum (wrap-around); out_ovf is reported identically in both builds.

Structure
REQ-026 SHALL place the state enum, the AW/W width helper functions and the signed/unsigned range-limit constants in shared package fp_pkg.
REQ-027 SHALL implement range checking and clamp/truncate in one combinational sub-module, fp_sat (AW in, W out plus ovf), reusable by later MAC blocks.

Verification (defaults W=16 Q2.14, ACC_LEN=9)
REQ-028 SHALL verify: 9 beats of 0x0800 back-to-back -> out_data=0x4800, out_ovf=0, out_valid on the cycle after beat 9.
REQ-029 SHALL verify: 9 beats of 0x4000 -> out_ovf=1; out_data=0x7FFF with FP_ACC_SATURATE_EN, 0x4000 without.
REQ-030 SHALL verify: 9 beats of 0xC000 (-1.0) -> out_data=0x8000 (saturated) or 0xC000 (wrapped), out_ovf=1.
REQ-031 SHALL verify: out_ready low for 5 cycles in HOLD -> out_data stable, in_ready=0, no extra beat absorbed; a following 9 x 0x0800 -> 0x4800.
REQ-032 SHALL verify: random in_valid gaps with operand 0x0400 -> out_data=0x2400, identical to the no-gap case.
REQ-033 SHALL verify: rst_n pulsed low after 4 beats of 0x4000, then 9 beats of 0x0800 -> single result 0x4800, out_ovf=0.
